instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 34 +++
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: word-wide memory read bus used by the instruction fetch unit.
//
// Signals:
//   address     fetch word address        (master -> slave)
//   read        read strobe               (master -> slave)
//   byteenable  byte-lane enables         (master -> slave)
//   waitrequest stall, read not accepted  (slave -> master)
//   readdata    read data, little-endian  (slave -> master)
//
// Modports: master (fetch unit side), slave (memory side).

interface instr_fetch_if;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address,
        output read,
        output byteenable,
        input  waitrequest,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  byteenable,
        output waitrequest,
        output readdata
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
//
// On fetch_start in IDLE the word address is latched and a read is issued on the
// bus from the next cycle. The read is held until waitrequest drops; the
// returned little-endian word is byte-swapped into instr and instr_valid pulses
// for one cycle. More than TIMEOUT_CYCLES consecutive stalled cycles send the
// unit to a sticky ERR state that only reset leaves.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   fetch_start  single-cycle fetch request
//   pc           fetch address
//   bus          memory read bus (instr_fetch_if.master)
//   instr        registered instruction word, big-endian order
//   instr_valid  one-cycle pulse when instr updates
//   fetch_busy   high while a fetch is outstanding
//   fetch_err    sticky error flag
//
// Parameters:
//   TIMEOUT_CYCLES  stalled cycles tolerated per fetch (1..255)
//   RESET_INSTR     reset value of instr
//
// Build option:
//   FETCH_ALIGN_CHECK_EN  when defined, a fetch_start with pc[1:0] != 0 issues
//                         no read and goes straight to ERR. When undefined,
//                         pc[1:0] is dropped from the address.

module instr_fetch #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_INSTR    = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_start,
    input  logic [31:0]          pc,
    instr_fetch_if.master        bus,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic                 fetch_busy,
    output logic                 fetch_err
);

    localparam logic [7:0] TimeoutCnt = TIMEOUT_CYCLES[7:0];

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StErr  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [7:0]  stall_q, stall_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            address_q     <= 32'h0;
            read_q        <= 1'b0;
            byteenable_q  <= 4'h0;
            instr_q       <= RESET_INSTR;
            instr_valid_q <= 1'b0;
            stall_q       <= 8'h0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            read_q        <= read_d;
            byteenable_q  <= byteenable_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            stall_q       <= stall_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        read_d        = read_q;
        byteenable_d  = byteenable_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        stall_d       = stall_q;

        unique case (state_q)
            StIdle: begin
                read_d       = 1'b0;
                byteenable_d = 4'h0;
                if (fetch_start) begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        state_d = StErr;
                    end else begin
                        address_d    = pc;
                        read_d       = 1'b1;
                        byteenable_d = 4'hF;
                        stall_d      = 8'h0;
                        state_d      = StReq;
                    end
`else
                    // Low address bits are dropped: fetches are always word aligned.
                    address_d    = pc & 32'hFFFF_FFFC;
                    read_d       = 1'b1;
                    byteenable_d = 4'hF;
                    stall_d      = 8'h0;
                    state_d      = StReq;
`endif
                end
            end

            StReq: begin
                if (!bus.waitrequest) begin
                    // Bus lanes are little-endian; instr holds the word big-endian.
                    instr_d       = {bus.readdata[7:0],   bus.readdata[15:8],
                                     bus.readdata[23:16], bus.readdata[31:24]};
                    instr_valid_d = 1'b1;
                    read_d        = 1'b0;
                    byteenable_d  = 4'h0;
                    state_d       = StIdle;
                end else if (stall_q == TimeoutCnt) begin
                    // Already tolerated TIMEOUT_CYCLES stalls and still stalled.
                    read_d       = 1'b0;
                    byteenable_d = 4'h0;
                    state_d      = StErr;
                end else if (stall_q != 8'hFF) begin
                    stall_d = stall_q + 8'd1;
                end
            end

            StErr: begin
                read_d       = 1'b0;
                byteenable_d = 4'h0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.address    = address_q;
    assign bus.read       = read_q;
    assign bus.byteenable = byteenable_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign fetch_busy     = (state_q == StReq);
    assign fetch_err      = (state_q == StErr);

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. Two instances share clock and
// reset: u_dut with default parameters and u_dut_to with TIMEOUT_CYCLES=4.

module tb_instr_fetch;

    logic        clk;
    logic        reset;

    logic        fetch_start;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_err;

    logic        fetch_start_b;
    logic [31:0] pc_b;
    logic [31:0] instr_b;
    logic        instr_valid_b;
    logic        fetch_busy_b;
    logic        fetch_err_b;

    int n_total;
    int n_bad;

    instr_fetch_if bus_a ();
    instr_fetch_if bus_b ();

    instr_fetch u_dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc          (pc),
        .bus         (bus_a),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .fetch_err   (fetch_err)
    );

    instr_fetch #(
        .TIMEOUT_CYCLES (4)
    ) u_dut_to (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start_b),
        .pc          (pc_b),
        .bus         (bus_b),
        .instr       (instr_b),
        .instr_valid (instr_valid_b),
        .fetch_busy  (fetch_busy_b),
        .fetch_err   (fetch_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset             = 1'b0;
        fetch_start       = 1'b0;
        pc                = 32'h0;
        bus_a.waitrequest = 1'b0;
        bus_a.readdata    = 32'h0;
        fetch_start_b     = 1'b0;
        pc_b              = 32'h0;
        bus_b.waitrequest = 1'b1;
        bus_b.readdata    = 32'h0;

        // Reset state, before any clock edge.
        #3;
        check_eq("rst_address", bus_a.address, 32'h0);
        check_eq("rst_read", {31'h0, bus_a.read}, 32'h0);
        check_eq("rst_be", {28'h0, bus_a.byteenable}, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_valid", {31'h0, instr_valid}, 32'h0);
        check_eq("rst_busy", {31'h0, fetch_busy}, 32'h0);
        check_eq("rst_err", {31'h0, fetch_err}, 32'h0);
        check_eq("rst_err_b", {31'h0, fetch_err_b}, 32'h0);
        tick();
        tick();
        reset = 1'b1;

        // Zero-wait fetch, byte swap, latency.
        pc             = 32'hBFC0_0000;
        fetch_start    = 1'b1;
        bus_a.readdata = 32'h0800_F03C;
        tick();
        fetch_start = 1'b0;
        check_eq("f1_read", {31'h0, bus_a.read}, 32'h1);
        check_eq("f1_address", bus_a.address, 32'hBFC0_0000);
        check_eq("f1_be", {28'h0, bus_a.byteenable}, 32'hF);
        check_eq("f1_busy", {31'h0, fetch_busy}, 32'h1);
        check_eq("f1_valid_early", {31'h0, instr_valid}, 32'h0);
        tick();
        check_eq("f1_valid", {31'h0, instr_valid}, 32'h1);
        check_eq("f1_instr", instr, 32'h3CF0_0008);
        check_eq("f1_read_off", {31'h0, bus_a.read}, 32'h0);
        check_eq("f1_busy_off", {31'h0, fetch_busy}, 32'h0);

        // Back-to-back start in the instr_valid cycle.
        pc             = 32'h0000_1000;
        fetch_start    = 1'b1;
        bus_a.readdata = 32'h4433_2211;
        tick();
        fetch_start = 1'b0;
        check_eq("b2b_valid_off", {31'h0, instr_valid}, 32'h0);
        check_eq("b2b_read", {31'h0, bus_a.read}, 32'h1);
        check_eq("b2b_address", bus_a.address, 32'h0000_1000);
        tick();
        check_eq("b2b_valid", {31'h0, instr_valid}, 32'h1);
        check_eq("b2b_instr", instr, 32'h1122_3344);
        tick();
        check_eq("b2b_valid_pulse", {31'h0, instr_valid}, 32'h0);
        check_eq("b2b_instr_hold", instr, 32'h1122_3344);

        // Five stalls, re-start during REQ ignored.
        pc                = 32'h2000_0010;
        fetch_start       = 1'b1;
        bus_a.waitrequest = 1'b1;
        bus_a.readdata    = 32'h7856_3412;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq("st_read", {31'h0, bus_a.read}, 32'h1);
            check_eq("st_address", bus_a.address, 32'h2000_0010);
            check_eq("st_busy", {31'h0, fetch_busy}, 32'h1);
            check_eq("st_valid", {31'h0, instr_valid}, 32'h0);
            if (i == 2) begin
                fetch_start = 1'b1;
                pc          = 32'hDEAD_0000;
            end
            if (i == 5) bus_a.waitrequest = 1'b0;
            tick();
            fetch_start = 1'b0;
        end
        check_eq("st_done_valid", {31'h0, instr_valid}, 32'h1);
        check_eq("st_done_instr", instr, 32'h1234_5678);
        check_eq("st_done_busy", {31'h0, fetch_busy}, 32'h0);
        tick();
        check_eq("st_single_valid", {31'h0, instr_valid}, 32'h0);
        check_eq("st_no_refetch", {31'h0, bus_a.read}, 32'h0);
        check_eq("st_addr_kept", bus_a.address, 32'h2000_0010);

        // Reset in the middle of a stalled read.
        pc                = 32'h0000_3000;
        fetch_start       = 1'b1;
        bus_a.waitrequest = 1'b1;
        tick();
        fetch_start = 1'b0;
        check_eq("mr_read", {31'h0, bus_a.read}, 32'h1);
        tick();
        reset = 1'b0;
        #1;
        check_eq("mr_read_rst", {31'h0, bus_a.read}, 32'h0);
        check_eq("mr_addr_rst", bus_a.address, 32'h0);
        check_eq("mr_instr_rst", instr, 32'h0);
        check_eq("mr_busy_rst", {31'h0, fetch_busy}, 32'h0);
        bus_a.waitrequest = 1'b0;
        bus_a.readdata    = 32'hAABB_CCDD;
        tick();
        check_eq("mr_no_valid", {31'h0, instr_valid}, 32'h0);
        reset = 1'b1;
        tick();
        check_eq("mr_no_valid2", {31'h0, instr_valid}, 32'h0);
        check_eq("mr_instr_kept", instr, 32'h0);
        check_eq("mr_read_idle", {31'h0, bus_a.read}, 32'h0);

        // Misaligned pc.
        pc             = 32'hBFC0_0002;
        fetch_start    = 1'b1;
        bus_a.readdata = 32'h0800_F03C;
        tick();
        fetch_start = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("al_read", {31'h0, bus_a.read}, 32'h0);
        check_eq("al_err", {31'h0, fetch_err}, 32'h1);
        tick();
        check_eq("al_no_valid", {31'h0, instr_valid}, 32'h0);
        check_eq("al_read2", {31'h0, bus_a.read}, 32'h0);
`else
        check_eq("al_read", {31'h0, bus_a.read}, 32'h1);
        check_eq("al_address", bus_a.address, 32'hBFC0_0000);
        tick();
        check_eq("al_valid", {31'h0, instr_valid}, 32'h1);
        check_eq("al_instr", instr, 32'h3CF0_0008);
        check_eq("al_err", {31'h0, fetch_err}, 32'h0);
`endif

        // TIMEOUT_CYCLES=4: waitrequest drops with 4 stalls counted -> success.
        pc_b              = 32'h0000_4000;
        fetch_start_b     = 1'b1;
        bus_b.waitrequest = 1'b1;
        bus_b.readdata    = 32'hEFBE_ADDE;
        tick();
        fetch_start_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("tb_ok_read", {31'h0, bus_b.read}, 32'h1);
            if (i == 4) bus_b.waitrequest = 1'b0;
            tick();
        end
        check_eq("tb_ok_valid", {31'h0, instr_valid_b}, 32'h1);
        check_eq("tb_ok_instr", instr_b, 32'hDEAD_BEEF);
        check_eq("tb_ok_err", {31'h0, fetch_err_b}, 32'h0);

        // TIMEOUT_CYCLES=4: waitrequest held -> ERR.
        pc_b              = 32'h0000_5000;
        fetch_start_b     = 1'b1;
        bus_b.waitrequest = 1'b1;
        tick();
        fetch_start_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("to_read", {31'h0, bus_b.read}, 32'h1);
            check_eq("to_err_early", {31'h0, fetch_err_b}, 32'h0);
            tick();
        end
        check_eq("to_err", {31'h0, fetch_err_b}, 32'h1);
        check_eq("to_read_off", {31'h0, bus_b.read}, 32'h0);
        check_eq("to_busy_off", {31'h0, fetch_busy_b}, 32'h0);
        check_eq("to_no_valid", {31'h0, instr_valid_b}, 32'h0);
        check_eq("to_instr_kept", instr_b, 32'hDEAD_BEEF);
        pc_b              = 32'h0000_6000;
        fetch_start_b     = 1'b1;
        bus_b.waitrequest = 1'b0;
        tick();
        fetch_start_b = 1'b0;
        tick();
        check_eq("to_start_ignored", {31'h0, bus_b.read}, 32'h0);
        check_eq("to_addr_kept", bus_b.address, 32'h0000_5000);
        check_eq("to_err_sticky", {31'h0, fetch_err_b}, 32'h1);
        check_eq("to_no_valid2", {31'h0, instr_valid_b}, 32'h0);

        reset = 1'b0;
        #1;
        check_eq("to_err_cleared", {31'h0, fetch_err_b}, 32'h0);
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
